// File: rtl/uart_tx_sched.sv
// Bus-master sequencer: programs the UART baud divisors after reset, then
// round-robin shares the UART transmit register between two byte requesters.
module uart_tx_sched #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  DIV0      = 8'd18,
    parameter logic [7:0]  DIV1      = 8'd65
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic [31:0] addr,
    output logic        read,
    output logic        write,
    output logic [2:0]  size,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        ready,
    output logic        init_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        INIT_A,
        INIT_D,
        IDLE,
        POLL_A,
        POLL_D,
        WR_A,
        WR_D
    } state_t;

    localparam logic [31:0] ADDR_BAUD   = BASE_ADDR;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h8;
    localparam logic [31:0] BAUD_WORD   = {16'h0000, DIV1, DIV0};
    localparam logic [2:0]  SIZE_WORD   = 3'b010;
    localparam logic [2:0]  SIZE_BYTE   = 3'b000;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  txbyte;
    logic        last_grant;
    logic        gnt0;
    logic        gnt1;
    logic        handshake;
    logic        txf;
    logic        unused_rdata;

    logic [31:0] addr_c;
    logic        read_c;
    logic        write_c;
    logic [2:0]  size_c;
    logic [31:0] wdata_c;

    assign txf          = rdata[1];
    assign unused_rdata = ^{rdata[31:2], rdata[0]};

    // last_grant == 1 means requester 1 won the previous arbitration
    assign gnt0      = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
    assign gnt1      = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);
    assign handshake = gnt0 || gnt1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= INIT_A;
            txbyte     <= '0;
            last_grant <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (handshake) begin
                txbyte     <= gnt1 ? req1_data : req0_data;
                last_grant <= gnt1;
            end
            if ((state == INIT_D) && ready) begin
                init_done <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        addr_c    = '0;
        read_c    = 1'b0;
        write_c   = 1'b0;
        size_c    = '0;
        wdata_c   = '0;
        case (state)
            INIT_A: begin
                write_c = 1'b1;
                addr_c  = ADDR_BAUD;
                size_c  = SIZE_WORD;
                wdata_c = BAUD_WORD;
                if (ready) state_nxt = INIT_D;
            end
            INIT_D: begin
                addr_c  = ADDR_BAUD;
                size_c  = SIZE_WORD;
                wdata_c = BAUD_WORD;
                if (ready) state_nxt = IDLE;
            end
            IDLE: begin
                if (handshake) state_nxt = POLL_A;
            end
            POLL_A: begin
                read_c = 1'b1;
                addr_c = ADDR_STATUS;
                size_c = SIZE_WORD;
                if (ready) state_nxt = POLL_D;
            end
            POLL_D: begin
                addr_c = ADDR_STATUS;
                size_c = SIZE_WORD;
                if (ready) state_nxt = txf ? POLL_A : WR_A;
            end
            WR_A: begin
                write_c = 1'b1;
                addr_c  = ADDR_DATA;
                size_c  = SIZE_BYTE;
                wdata_c = {24'h0, txbyte};
                if (ready) state_nxt = WR_D;
            end
            WR_D: begin
                addr_c  = ADDR_DATA;
                size_c  = SIZE_BYTE;
                wdata_c = {24'h0, txbyte};
                if (ready) state_nxt = IDLE;
            end
            default: state_nxt = INIT_A;
        endcase
    end

    // The state register already sits in INIT_A while resetn is low, so the
    // decode is masked to keep the bus quiet for the whole reset cycle.
    assign addr       = resetn ? addr_c  : '0;
    assign read       = resetn && read_c;
    assign write      = resetn && write_c;
    assign size       = resetn ? size_c  : '0;
    assign wdata      = resetn ? wdata_c : '0;
    assign req0_ready = resetn && gnt0;
    assign req1_ready = resetn && gnt1;
    assign busy       = !resetn || (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched with immediate assertions.
module tb_uart_tx_sched;

    logic        clk;
    logic        resetn;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic [31:0] addr;
    logic        read;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        init_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_tx_sched #(
        .BASE_ADDR(32'h0000_0000),
        .DIV0(8'd18),
        .DIV1(8'd65)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_ready(req1_ready),
        .addr(addr),
        .read(read),
        .write(write),
        .size(size),
        .wdata(wdata),
        .rdata(rdata),
        .ready(ready),
        .init_done(init_done),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int          reads;
    int          writes;
    int          reads_at_write;
    int          lat;
    int          nwr;
    int          bad;
    logic        done;
    logic [31:0] wbyte;
    logic [7:0]  got [4];
    logic [7:0]  exp_rr [4];

    initial begin
        resetn     = 1'b0;
        ready      = 1'b1;
        rdata      = '0;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
        repeat (3) tick();

        chk("rst_write", {31'b0, write}, 32'd0);
        chk("rst_read", {31'b0, read}, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_size", {29'b0, size}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_init_done", {31'b0, init_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);

        // Requester 0 asks early; must not be accepted before IDLE
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        resetn     = 1'b1;
        #1;
        chk("inita_write", {31'b0, write}, 32'd1);
        chk("inita_addr", addr, 32'h0);
        chk("inita_size", {29'b0, size}, 32'd2);
        chk("inita_wdata", wdata, 32'h0000_4112);
        chk("inita_rdy0", {31'b0, req0_ready}, 32'd0);
        tick();
        chk("initd_write", {31'b0, write}, 32'd0);
        chk("initd_wdata", wdata, 32'h0000_4112);
        chk("initd_done", {31'b0, init_done}, 32'd0);
        chk("initd_rdy0", {31'b0, req0_ready}, 32'd0);
        tick();
        chk("idle_done", {31'b0, init_done}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_rdy0", {31'b0, req0_ready}, 32'd1);
        chk("idle_rdy1", {31'b0, req1_ready}, 32'd0);

        // Byte 0x41, status clear: POLL_A, POLL_D, WR_A, WR_D, IDLE
        tick();
        req0_valid = 1'b0;
        req0_data  = 8'hFF;
        chk("p41_read", {31'b0, read}, 32'd1);
        chk("p41_addr", addr, 32'h4);
        chk("p41_size", {29'b0, size}, 32'd2);
        chk("p41_write", {31'b0, write}, 32'd0);
        tick();
        chk("pd41_rw", {30'b0, read, write}, 32'd0);
        tick();
        chk("w41_write", {31'b0, write}, 32'd1);
        chk("w41_addr", addr, 32'h8);
        chk("w41_size", {29'b0, size}, 32'd0);
        chk("w41_wdata", wdata, 32'h41);
        tick();
        chk("wd41_write", {31'b0, write}, 32'd0);
        chk("wd41_wdata", wdata, 32'h41);
        tick();
        chk("idle41_busy", {31'b0, busy}, 32'd0);

        // Byte 0x5C from requester 1 with three TXF=1 polls: latency 11
        req1_valid = 1'b1;
        req1_data  = 8'h5C;
        #1;
        chk("txf_rdy1", {31'b0, req1_ready}, 32'd1);
        chk("txf_rdy0", {31'b0, req0_ready}, 32'd0);
        reads = 0; writes = 0; reads_at_write = -1; lat = 0; done = 1'b0; wbyte = '0;
        for (int c = 1; c <= 40 && !done; c++) begin
            tick();
            req1_valid = 1'b0;
            if (read && addr == 32'h4) reads++;
            if (write && addr == 32'h8) begin
                writes++;
                wbyte = wdata;
                reads_at_write = reads;
            end
            rdata = (reads <= 3) ? 32'h2 : 32'h0;
            if (!busy) begin
                done = 1'b1;
                lat  = c;
            end
        end
        rdata = '0;
        chk("txf_done", {31'b0, done}, 32'd1);
        chk("txf_latency", lat, 32'd11);
        chk("txf_reads", reads, 32'd4);
        chk("txf_reads_before_wr", reads_at_write, 32'd4);
        chk("txf_writes", writes, 32'd1);
        chk("txf_wdata", wbyte, 32'h5C);

        // Stall two cycles in WR_D
        req0_valid = 1'b1;
        req0_data  = 8'h77;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        chk("st_wra_write", {31'b0, write}, 32'd1);
        tick();
        ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("st_hold_wdata", wdata, 32'h77);
            chk("st_hold_addr", addr, 32'h8);
            chk("st_hold_size", {29'b0, size}, 32'd0);
            chk("st_hold_rw", {30'b0, read, write}, 32'd0);
            chk("st_hold_busy", {31'b0, busy}, 32'd1);
        end
        ready = 1'b1;
        tick();
        chk("st_release_busy", {31'b0, busy}, 32'd0);

        // Reset during POLL_D: divisor write comes next, 0x99 never written
        req1_valid = 1'b1;
        req1_data  = 8'h99;
        tick();
        req1_valid = 1'b0;
        chk("rp_polla_read", {31'b0, read}, 32'd1);
        tick();
        rdata  = 32'h2;
        resetn = 1'b0;
        tick();
        rdata = '0;
        chk("rp_rst_rw", {30'b0, read, write}, 32'd0);
        chk("rp_rst_done", {31'b0, init_done}, 32'd0);
        resetn = 1'b1;
        #1;
        chk("rp_inita_write", {31'b0, write}, 32'd1);
        chk("rp_inita_addr", addr, 32'h0);
        chk("rp_inita_wdata", wdata, 32'h0000_4112);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (write && addr == 32'h8) bad++;
        end
        chk("rp_no_stale_write", bad, 32'd0);
        chk("rp_done", {31'b0, init_done}, 32'd1);
        chk("rp_idle", {31'b0, busy}, 32'd0);

        // Both requesters held valid: first contention after reset goes to req0
        req0_valid = 1'b1;
        req0_data  = 8'hA0;
        req1_valid = 1'b1;
        req1_data  = 8'hB0;
        #1;
        chk("rr_first_rdy0", {31'b0, req0_ready}, 32'd1);
        chk("rr_first_rdy1", {31'b0, req1_ready}, 32'd0);
        exp_rr[0] = 8'hA0; exp_rr[1] = 8'hB0; exp_rr[2] = 8'hA0; exp_rr[3] = 8'hB0;
        nwr = 0;
        for (int c = 0; c < 60 && nwr < 4; c++) begin
            tick();
            if (write && addr == 32'h8) begin
                got[nwr] = wdata[7:0];
                nwr++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_count", nwr, 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_byte%0d", i), {24'b0, got[i]}, {24'b0, exp_rr[i]});
        end
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk("rr_drain", {31'b0, done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
